// File: rtl/flux_pkg.sv
// Shared types and helpers for the flux scheduler: state encoding, tag width
// derivation and modulo-N pointer increment.
package flux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // A single flux still needs a 1-bit tag so the port never collapses to zero width.
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/flux_scheduler_rr_pick.sv
// Combinational rotate-search: first set bit of req at or after ptr, wrapping
// at FLUX (which need not be a power of two).
module rr_pick
    import flux_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = tag_w(FLUX)
) (
    input  logic [FLUX-1:0]      req,
    input  logic [TAG_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [TAG_WIDTH-1:0] idx
);

    always_comb begin
        logic [TAG_WIDTH-1:0] cand;
        // NOTE: every output gets a default before any branch; a path that
        // skips an assignment would otherwise infer a latch.
        cand  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < FLUX; i++) begin
            cand = TAG_WIDTH'((int'(ptr) + i) % FLUX);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/flux_scheduler.sv
// Round-robin, burst-locking flux arbiter: grants one flux per cycle and keeps
// it for up to BURST fires (or until it ends a block) so rows stay contiguous.
module flux_scheduler
    import flux_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = tag_w(FLUX),
    parameter int BURST     = 8,
    parameter int WAIT_MAX  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX-1:0]      req,
    input  logic                 fire,
    input  logic                 last,
    output logic                 valid,
    output logic [FLUX-1:0]      grant,
    output logic [TAG_WIDTH-1:0] tag
);

    localparam int BCW = $clog2(BURST + 1);
    localparam int WCW = $clog2(WAIT_MAX + 1);
    localparam logic [BCW-1:0] BURST_LIM = BCW'(BURST);
    localparam logic [WCW-1:0] WAIT_LIM  = WCW'(WAIT_MAX);

    state_t               state, state_nxt;
    logic [TAG_WIDTH-1:0] ptr, ptr_nxt;
    logic [TAG_WIDTH-1:0] owner, owner_nxt;
    logic [BCW-1:0]       burst_cnt, burst_nxt;
    logic [WCW-1:0]       wait_cnt, wait_nxt;

    logic                 pick_found;
    logic [TAG_WIDTH-1:0] pick_idx;

    rr_pick #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
            wait_cnt  <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        wait_nxt  = wait_cnt;
        valid     = 1'b0;
        tag       = '0;

        unique case (state)
            IDLE: begin
                valid = pick_found;
                tag   = pick_found ? pick_idx : '0;
                if (pick_found && fire) begin
                    if (last || BURST == 1) begin
                        ptr_nxt = TAG_WIDTH'(wrap_inc(int'(pick_idx), FLUX));
                    end else begin
                        state_nxt = HOLD;
                        owner_nxt = pick_idx;
                        burst_nxt = BCW'(1);
                        wait_nxt  = '0;
                    end
                end
            end

            HOLD: begin
                if (req[owner]) begin
                    valid    = 1'b1;
                    tag      = owner;
                    wait_nxt = '0;
                    if (fire) begin
                        if (last || (burst_cnt + BCW'(1) == BURST_LIM)) begin
                            state_nxt = IDLE;
                            ptr_nxt   = TAG_WIDTH'(wrap_inc(int'(owner), FLUX));
                            burst_nxt = '0;
                        end else begin
                            burst_nxt = burst_cnt + BCW'(1);
                        end
                    end
                end else begin
                    // Other fluxes stay blocked so the owner's row is not split.
                    wait_nxt = wait_cnt + WCW'(1);
                    if (wait_cnt + WCW'(1) == WAIT_LIM) begin
                        state_nxt = IDLE;
                        ptr_nxt   = TAG_WIDTH'(wrap_inc(int'(owner), FLUX));
                        burst_nxt = '0;
                        wait_nxt  = '0;
                    end
                end
            end

            default: ;
        endcase
    end

    always_comb begin
        grant = '0;
        if (valid) grant[tag] = 1'b1;
    end

endmodule

// File: tb/tb_flux_scheduler.sv
// Directed self-checking bench for flux_scheduler: a FLUX=2 instance for burst,
// wait and reset behaviour and a FLUX=3 instance for non-power-of-two wrap.
module tb_flux_scheduler;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic       fire, last;
    logic       valid;
    logic [1:0] grant;
    logic       tag;

    logic [2:0] req3;
    logic       fire3, last3;
    logic       valid3;
    logic [2:0] grant3;
    logic [1:0] tag3;

    int checks   = 0;
    int failures = 0;

    flux_scheduler #(.FLUX(2), .BURST(8), .WAIT_MAX(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .fire  (fire),
        .last  (last),
        .valid (valid),
        .grant (grant),
        .tag   (tag)
    );

    flux_scheduler #(.FLUX(3), .BURST(8), .WAIT_MAX(4)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .req   (req3),
        .fire  (fire3),
        .last  (last3),
        .valid (valid3),
        .grant (grant3),
        .tag   (tag3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled 2 time units later, well clear of either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the FLUX=2 instance's outputs against a flux index (-1 = no grant).
    task automatic expect2(input string name, input int exp_tag);
        #2;
        if (exp_tag < 0) begin
            check({name, ".valid"}, int'(valid), 0);
            check({name, ".grant"}, int'(grant), 0);
            check({name, ".tag"},   int'(tag),   0);
        end else begin
            check({name, ".valid"}, int'(valid), 1);
            check({name, ".grant"}, int'(grant), 1 << exp_tag);
            check({name, ".tag"},   int'(tag),   exp_tag);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        fire = 1'b0;
        last = 1'b0;
        req3 = '0;
        fire3 = 1'b0;
        last3 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; fire = 1'b0; last = 1'b0;
        req3 = '0; fire3 = 1'b0; last3 = 1'b0;
        #1;

        // Reset state with no requests.
        tick();
        expect2("reset", -1);
        #2;
        check("reset3.valid", int'(valid3), 0);
        check("reset3.grant", int'(grant3), 0);
        rst = 1'b0;

        // Continuous fire on both fluxes: bursts of 8 alternate 0,1,0; ptr ends at 1.
        req = 2'b11; fire = 1'b1; last = 1'b0;
        for (int k = 0; k < 24; k++) begin
            expect2($sformatf("burst[%0d]", k), (k / 8) % 2);
            tick();
        end

        // Only flux 0 requesting, no fire: search wraps from ptr=1 to 0, nothing moves.
        req = 2'b01; fire = 1'b0;
        for (int k = 0; k < 10; k++) begin
            expect2($sformatf("nofire[%0d]", k), 0);
            tick();
        end
        req = 2'b11;
        expect2("ptr_kept", 1);

        // HOLD on flux 1 after 3 fires; owner drops for WAIT_MAX cycles, fire ignored.
        do_reset();
        req = 2'b10; fire = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect2($sformatf("own1[%0d]", k), 1);
            tick();
        end
        req = 2'b01;
        for (int k = 0; k < 4; k++) begin
            expect2($sformatf("wait1[%0d]", k), -1);
            tick();
        end
        req = 2'b11; fire = 1'b0;
        expect2("abandon", 0);

        // Short drop on flux 0 keeps ownership; burst resumes at 3 and expires after 5 more.
        do_reset();
        req = 2'b01; fire = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect2($sformatf("own0[%0d]", k), 0);
            tick();
        end
        req = 2'b10;
        for (int k = 0; k < 2; k++) begin
            expect2($sformatf("drop0[%0d]", k), -1);
            tick();
        end
        req = 2'b11;
        for (int k = 0; k < 5; k++) begin
            expect2($sformatf("resume0[%0d]", k), 0);
            tick();
        end
        expect2("rotate_after_resume", 1);

        // Reset mid-burst on flux 1 (count 5): fresh start from flux 0 with a full burst.
        do_reset();
        req = 2'b10; fire = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        expect2("mid_burst_owner", 1);
        rst = 1'b1; req = 2'b11; fire = 1'b0;
        tick();
        rst = 1'b0;
        expect2("post_rst", 0);
        fire = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expect2($sformatf("fresh[%0d]", k), 0);
            tick();
        end
        expect2("fresh_rotate", 1);

        // FLUX=3, fire with last every cycle: single-op rotation 0,1,2,0,1,2.
        do_reset();
        req3 = 3'b111; fire3 = 1'b1; last3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #2;
            check($sformatf("f3[%0d].valid", k), int'(valid3), 1);
            check($sformatf("f3[%0d].tag", k),   int'(tag3),   k % 3);
            check($sformatf("f3[%0d].grant", k), int'(grant3), 1 << (k % 3));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flux_scheduler.md
Name: flux_scheduler

Overview:
- Round-robin, burst-locking arbiter that picks which data flux (tag) a multi-flux dataflow actor services each cycle. It replaces fixed lowest-index priority, which can starve higher tags.
- Sits beside a multi-flux actor such as the HEVC line buffer. Per-flux "ready" conditions come in; a one-hot grant and a binary tag go out.
- Holds a flux for up to BURST consecutive operations, or until the flux ends its block, so a row stays contiguous in the downstream FIFO.

Parameters:
- FLUX, 2, number of multiplexed data fluxes (>=1).
- TAG_WIDTH, max(1,$clog2(FLUX)), width of tag output.
- BURST, 8, maximum consecutive fires granted to one flux before forced rotation (>=1).
- WAIT_MAX, 4, consecutive cycles an owning flux may drop its request before ownership is abandoned (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req  in  FLUX  per-flux ready (actor firing condition met for flux i).
- fire  in  1  granted operation actually executed this cycle. Meaningful only when valid=1; ignored otherwise.
- last  in  1  qualifies fire: this operation ends a block (e.g. IDLE return). Ignored unless fire & valid.
- valid  out  1  a grant is issued this cycle.
- grant  out  FLUX  one-hot grant; all zero when valid=0.
- tag  out  TAG_WIDTH  binary index of the granted flux; 0 when valid=0.

Behaviour:
- Reset (rst: synchronous, active-high; clock clk):
  - state=IDLE, ptr=0, owner=0, burst_cnt=0, wait_cnt=0.
  - Outputs follow combinationally: valid=0, grant=0, tag=0 while req=0.
- Outputs are combinational from registered state and current req, with zero latency. State updates on posedge clk.
- States: IDLE (no owner), HOLD (owner locked).
- IDLE:
  - Search req starting at ptr, ascending with wrap at FLUX (FLUX need not be a power of 2). The first set bit is granted; valid=|req.
  - On fire, if last or BURST==1: stay IDLE, ptr<=(tag+1) mod FLUX.
  - On fire otherwise: go to HOLD, owner<=tag, burst_cnt<=1, wait_cnt<=0.
  - With no fire, all registers hold. Ptr does not move on grant alone.
- HOLD:
  - If req[owner]=1: grant owner, valid=1, wait_cnt<=0.
    - On fire with last, or with burst_cnt+1==BURST: go to IDLE, ptr<=(owner+1) mod FLUX, burst_cnt<=0.
    - On fire otherwise: burst_cnt<=burst_cnt+1.
  - If req[owner]=0: valid=0. Other fluxes are not granted, to preserve contiguity. wait_cnt<=wait_cnt+1.
    - When wait_cnt+1==WAIT_MAX: go to IDLE, ptr<=(owner+1) mod FLUX, burst_cnt<=0, wait_cnt<=0.
- Simultaneous events: last and burst expiry together produce a single return to IDLE.
- fire while valid=0 changes nothing.
- rst overrides everything, including mid-burst. Ownership is lost and ptr returns to 0.
- Counter widths: burst_cnt is $clog2(BURST+1) bits and wait_cnt is $clog2(WAIT_MAX+1) bits. Neither can overflow, because each resets on reaching its limit.
- Invariants: grant is one-hot or zero. tag==index(grant). valid implies req[tag].

Decomposition:
- Shared package flux_pkg holds:
  - the state enum (IDLE, HOLD);
  - a function tag_w(FLUX) returning max(1,$clog2(FLUX));
  - a wrap-increment function.
- Sub-module rr_pick(FLUX): combinational rotate-search of req from a start pointer, returning found and index. Instantiated once in the scheduler.

Test Plan:
- Reset then req=2'b11, fire=1 every cycle, last=0, BURST=8 -> tag=0 for 8 cycles, then tag=1 for 8 cycles, alternating. valid stays 1 and grant stays one-hot.
- FLUX=3, req=3'b111, fire=1, last=1 every cycle -> tag sequence 0,1,2,0,1,2. State never leaves IDLE.
- HOLD on flux 1 after 3 fires, then req[1]=0 with req[0]=1, WAIT_MAX=4 -> valid=0 for 4 cycles, then tag=0 granted. After the flux-1 fire, ptr=2 mod 2=0.
- HOLD on flux 0, req[0] drops for 2 cycles and returns -> ownership is kept, grant resumes on flux 0, and burst_cnt continues from 3.
- req=2'b01, fire=0 for 10 cycles -> tag=0, valid=1 throughout. State stays IDLE and ptr is unchanged.
- Mid-burst (burst_cnt=5, owner=1), pulse rst, then req=2'b11 -> tag=0 immediately. A fresh burst starts at count 0.
